cfi_shadow_stack: RTL and testbench

- Parametrised control-flow-integrity monitor on the Ariane commit interface.
- Keeps a hardware shadow return-address stack:
  - pushes the link address on every committed call;
  - pops on every committed return;
  - checks that the next committed PC equals the popped address.
- Optionally enforces landing pads after indirect jumps.
- Violation is sticky; raises flow_integrity_violated_o toward the commit stage and a debug/CSR observer.

---
 rtl/cfi_shadow_stack.sv | 228 ++++++++++++++++++++++
 tb/tb_cfi_shadow_stack.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfi_shadow_stack.sv
// cfi_shadow_stack: control-flow-integrity monitor on the commit interface.
// Keeps a circular shadow return-address stack, checks every return target
// against it and latches the first violation until clear or reset.
// Optional build macro: CFI_LANDING_PAD_EN -- when defined, indirect jumps
// must be followed by a landing pad (ADD x0, x1 with result[1:0] == 2'b11).

package cfi_shadow_stack_pkg;
  localparam int unsigned NR_COMMIT_PORTS = 2;
  localparam int unsigned VLEN            = 64;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
  } fu_t;

  typedef enum logic [3:0] {
    ADD, SUB, XORL, ORL, ANDL, SLTS, JALR, JAL, EQ, NE
  } fu_op;

  typedef struct packed {
    fu_op            op;
    fu_t             fu;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [VLEN-1:0] pc;
    logic            is_compressed;
    logic [VLEN-1:0] result;
  } scoreboard_entry_t;
endpackage

module cfi_shadow_stack
  import cfi_shadow_stack_pkg::*;
#(
  parameter int unsigned NR_PORTS = NR_COMMIT_PORTS,
  parameter int unsigned SS_DEPTH = 8,
  parameter int unsigned PC_W     = VLEN
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  scoreboard_entry_t [NR_PORTS-1:0]  commit_instr_i,
  input  logic [NR_PORTS-1:0]               commit_ack_i,
  input  logic                              clear_i,
  output logic                              flow_integrity_violated_o,
  output logic [1:0]                        violation_cause_o,
  output logic [PC_W-1:0]                   violation_pc_o,
  output logic [$clog2(SS_DEPTH):0]         ss_count_o,
  output logic                              ss_overflow_o,
  output logic [1:0]                        state_o
);

  localparam int unsigned PTR_W = $clog2(SS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] CAUSE_NONE         = 2'b00;
  localparam logic [1:0] CAUSE_RET_MISMATCH = 2'b01;
  localparam logic [1:0] CAUSE_UNDERFLOW    = 2'b10;
`ifdef CFI_LANDING_PAD_EN
  localparam logic [1:0] CAUSE_NO_PAD       = 2'b11;
`endif

  typedef enum logic [1:0] {
    S_CHECK      = 2'd0,
    S_EXPECT_RET = 2'd1,
    S_EXPECT_PAD = 2'd2,
    S_VIOLATED   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W-1:0]    exp_pc_q, exp_pc_d;
  logic [1:0]         cause_q, cause_d;
  logic [PC_W-1:0]    vpc_q, vpc_d;
  logic               overflow_q, overflow_d;
  logic               violated_q, violated_d;
  logic [PC_W-1:0]    stack_q [SS_DEPTH];
  logic [PC_W-1:0]    stack_d [SS_DEPTH];

  logic               classify;
  logic [PC_W-1:0]    cur_pc;
  logic [PC_W-1:0]    link_addr;

  // Fields such as the upper result bits are not needed by the monitor.
  logic unused_instr;
  assign unused_instr = ^commit_instr_i;

  function automatic logic is_call(scoreboard_entry_t e);
    return (e.fu == CTRL_FLOW) && ((e.op == JAL) || (e.op == JALR)) && (e.rd == 5'd1);
  endfunction

  function automatic logic is_return(scoreboard_entry_t e);
    return (e.fu == CTRL_FLOW) && (e.op == JALR) && (e.rd == 5'd0) && (e.rs1 == 5'd1);
  endfunction

`ifdef CFI_LANDING_PAD_EN
  function automatic logic is_indirect_jump(scoreboard_entry_t e);
    return (e.fu == CTRL_FLOW) && (e.op == JALR) && (e.rd == 5'd0) && (e.rs1 != 5'd1);
  endfunction

  function automatic logic is_landing_pad(scoreboard_entry_t e);
    return (e.fu == ALU) && (e.op == ADD) && (e.rd == 5'd0) && (e.rs1 == 5'd1) &&
           (e.result[1:0] == 2'b11);
  endfunction
`endif

  // Next-state: walk acked ports in ascending order, each seeing the
  // state left behind by the lower-indexed port.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    exp_pc_d   = exp_pc_q;
    cause_d    = cause_q;
    vpc_d      = vpc_q;
    overflow_d = overflow_q;
    stack_d    = stack_q;
    classify   = 1'b0;
    cur_pc     = '0;
    link_addr  = '0;

    if (clear_i) begin
      state_d    = S_CHECK;
      ptr_d      = '0;
      count_d    = '0;
      exp_pc_d   = '0;
      cause_d    = CAUSE_NONE;
      vpc_d      = '0;
      overflow_d = 1'b0;
    end else begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (commit_ack_i[p] && (state_d != S_VIOLATED)) begin
          cur_pc   = commit_instr_i[p].pc[PC_W-1:0];
          classify = 1'b1;
          if (state_d == S_EXPECT_RET) begin
            // Target check first; a matching instr is then classified itself.
            if (cur_pc == exp_pc_d) begin
              state_d = S_CHECK;
            end else begin
              state_d  = S_VIOLATED;
              cause_d  = CAUSE_RET_MISMATCH;
              vpc_d    = cur_pc;
              classify = 1'b0;
            end
          end
`ifdef CFI_LANDING_PAD_EN
          else if (state_d == S_EXPECT_PAD) begin
            classify = 1'b0;
            if (is_landing_pad(commit_instr_i[p])) begin
              state_d = S_CHECK;
            end else begin
              state_d = S_VIOLATED;
              cause_d = CAUSE_NO_PAD;
              vpc_d   = cur_pc;
            end
          end
`endif
          if (classify) begin
            if (is_call(commit_instr_i[p])) begin
              // When full, ptr already points at the oldest entry, so the
              // write overwrites it and the count saturates.
              link_addr = cur_pc + (commit_instr_i[p].is_compressed ? PC_W'(2) : PC_W'(4));
              stack_d[ptr_d] = link_addr;
              ptr_d = ptr_d + 1'b1;
              if (count_d == CNT_W'(SS_DEPTH)) begin
                overflow_d = 1'b1;
              end else begin
                count_d = count_d + 1'b1;
              end
            end else if (is_return(commit_instr_i[p])) begin
              if (count_d == '0) begin
                state_d = S_VIOLATED;
                cause_d = CAUSE_UNDERFLOW;
                vpc_d   = cur_pc;
              end else begin
                ptr_d    = ptr_d - 1'b1;
                exp_pc_d = stack_d[ptr_d];
                count_d  = count_d - 1'b1;
                state_d  = S_EXPECT_RET;
              end
            end
`ifdef CFI_LANDING_PAD_EN
            else if (is_indirect_jump(commit_instr_i[p])) begin
              state_d = S_EXPECT_PAD;
            end
`endif
          end
        end
      end
    end

    violated_d = (state_d == S_VIOLATED);
  end

  // Control and status registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_CHECK;
      ptr_q      <= '0;
      count_q    <= '0;
      exp_pc_q   <= '0;
      cause_q    <= CAUSE_NONE;
      vpc_q      <= '0;
      overflow_q <= 1'b0;
      violated_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      exp_pc_q   <= exp_pc_d;
      cause_q    <= cause_d;
      vpc_q      <= vpc_d;
      overflow_q <= overflow_d;
      violated_q <= violated_d;
    end
  end

  // Stack storage needs no reset: entries are only read below a valid count.
  always_ff @(posedge clk_i) begin
    stack_q <= stack_d;
  end

  assign flow_integrity_violated_o = violated_q;
  assign violation_cause_o         = cause_q;
  assign violation_pc_o            = vpc_q;
  assign ss_count_o                = count_q;
  assign ss_overflow_o             = overflow_q;
  assign state_o                   = state_q;

endmodule

// File: tb/tb_cfi_shadow_stack.sv
// Scoreboard bench for cfi_shadow_stack: the driver updates a queue-based
// reference model per commit and pushes the expected output snapshot after
// each clock edge; the monitor pops and compares on the following negedge.
module tb_cfi_shadow_stack;
  import cfi_shadow_stack_pkg::*;

  localparam int PW    = 32;
  localparam int DEPTH = 8;

  localparam logic [1:0] ST_CHK  = 2'd0;
  localparam logic [1:0] ST_RET  = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_VIOL = 2'd3;

  logic                         clk = 1'b0;
  logic                         rst_ni;
  scoreboard_entry_t [1:0]      commit_instr;
  logic [1:0]                   commit_ack;
  logic                         clear;
  logic                         viol;
  logic [1:0]                   cause;
  logic [PW-1:0]                vpc;
  logic [$clog2(DEPTH):0]       cnt;
  logic                         ovf;
  logic [1:0]                   st;

  always #5 clk = ~clk;

  cfi_shadow_stack #(.NR_PORTS(2), .SS_DEPTH(DEPTH), .PC_W(PW)) dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_ni),
    .commit_instr_i           (commit_instr),
    .commit_ack_i             (commit_ack),
    .clear_i                  (clear),
    .flow_integrity_violated_o(viol),
    .violation_cause_o        (cause),
    .violation_pc_o           (vpc),
    .ss_count_o               (cnt),
    .ss_overflow_o            (ovf),
    .state_o                  (st)
  );

  // ---------------- reference model ----------------
  logic [PW-1:0] m_stack[$];
  logic [1:0]    m_state = ST_CHK;
  logic [PW-1:0] m_exp   = '0;
  logic [1:0]    m_cause = 2'b00;
  logic [PW-1:0] m_vpc   = '0;
  logic          m_ovf   = 1'b0;

  typedef struct {
    logic          viol;
    logic [1:0]    cause;
    logic [PW-1:0] vpc;
    int            count;
    logic          ovf;
    logic [1:0]    state;
  } snap_t;

  snap_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  function automatic bit m_is_call(scoreboard_entry_t e);
    return e.fu == CTRL_FLOW && (e.op == JAL || e.op == JALR) && e.rd == 5'd1;
  endfunction
  function automatic bit m_is_ret(scoreboard_entry_t e);
    return e.fu == CTRL_FLOW && e.op == JALR && e.rd == 5'd0 && e.rs1 == 5'd1;
  endfunction
  function automatic bit m_is_ijmp(scoreboard_entry_t e);
    return e.fu == CTRL_FLOW && e.op == JALR && e.rd == 5'd0 && e.rs1 != 5'd1;
  endfunction
  function automatic bit m_is_pad(scoreboard_entry_t e);
    return e.fu == ALU && e.op == ADD && e.rd == 5'd0 && e.rs1 == 5'd1 && e.result[1:0] == 2'b11;
  endfunction

  function automatic void model_violate(logic [1:0] c, logic [PW-1:0] pc);
    m_state = ST_VIOL;
    m_cause = c;
    m_vpc   = pc;
  endfunction

  function automatic void model_clear();
    m_stack.delete();
    m_state = ST_CHK;
    m_exp   = '0;
    m_cause = 2'b00;
    m_vpc   = '0;
    m_ovf   = 1'b0;
  endfunction

  function automatic void model_commit(scoreboard_entry_t e);
    logic [PW-1:0] pc;
    pc = e.pc[PW-1:0];
    if (m_state == ST_VIOL) return;
    if (m_state == ST_RET) begin
      if (pc != m_exp) begin
        model_violate(2'b01, pc);
        return;
      end
      m_state = ST_CHK;
    end else if (m_state == ST_PAD) begin
      if (m_is_pad(e)) m_state = ST_CHK;
      else model_violate(2'b11, pc);
      return;
    end
    if (m_is_call(e)) begin
      m_stack.push_back(pc + (e.is_compressed ? 32'd2 : 32'd4));
      if (m_stack.size() > DEPTH) begin
        void'(m_stack.pop_front());
        m_ovf = 1'b1;
      end
    end else if (m_is_ret(e)) begin
      if (m_stack.size() == 0) model_violate(2'b10, pc);
      else begin
        m_exp   = m_stack.pop_back();
        m_state = ST_RET;
      end
    end else if (m_is_ijmp(e)) begin
`ifdef CFI_LANDING_PAD_EN
      m_state = ST_PAD;
`endif
    end
  endfunction

  function automatic void push_expect();
    snap_t s;
    s.viol  = (m_state == ST_VIOL);
    s.cause = m_cause;
    s.vpc   = m_vpc;
    s.count = m_stack.size();
    s.ovf   = m_ovf;
    s.state = m_state;
    exp_q.push_back(s);
  endfunction

  // ---------------- instruction builders ----------------
  function automatic scoreboard_entry_t mk(fu_op op, fu_t fu, logic [4:0] rs1, logic [4:0] rd,
                                           logic [PW-1:0] pc, logic c, logic [63:0] res);
    scoreboard_entry_t e;
    e.op = op; e.fu = fu; e.rs1 = rs1; e.rd = rd;
    e.pc = {32'h0, pc}; e.is_compressed = c; e.result = res;
    return e;
  endfunction
  function automatic scoreboard_entry_t i_call(logic [PW-1:0] pc, logic c);
    return mk(JAL, CTRL_FLOW, 5'd0, 5'd1, pc, c, 64'h0);
  endfunction
  function automatic scoreboard_entry_t i_ret(logic [PW-1:0] pc);
    return mk(JALR, CTRL_FLOW, 5'd1, 5'd0, pc, 1'b0, 64'h0);
  endfunction
  function automatic scoreboard_entry_t i_ijmp(logic [PW-1:0] pc);
    return mk(JALR, CTRL_FLOW, 5'd5, 5'd0, pc, 1'b0, 64'h0);
  endfunction
  function automatic scoreboard_entry_t i_pad(logic [PW-1:0] pc);
    return mk(ADD, ALU, 5'd1, 5'd0, pc, 1'b0, 64'h3);
  endfunction
  function automatic scoreboard_entry_t i_alu(logic [PW-1:0] pc);   // addi x5, x5, 0
    return mk(ADD, ALU, 5'd5, 5'd5, pc, 1'b0, 64'h0);
  endfunction

  function automatic scoreboard_entry_t gen_instr();
    int k;
    logic [PW-1:0] pc;
    scoreboard_entry_t e;
    k  = $urandom_range(0, 99);
    pc = $urandom & 32'hFFFF_FFFE;
    if (m_state == ST_RET && $urandom_range(0, 9) < 8) pc = m_exp;
    if (m_state == ST_PAD && k < 60) e = i_pad(pc);
    else if (k < 30) e = mk(($urandom_range(0, 1) != 0) ? JAL : JALR, CTRL_FLOW,
                            5'($urandom_range(0, 31)), 5'd1, pc, 1'($urandom_range(0, 1)), 64'($urandom));
    else if (k < 55) e = i_ret(pc);
    else if (k < 65) e = mk(JALR, CTRL_FLOW, 5'($urandom_range(2, 31)), 5'd0, pc, 1'b0, 64'h0);
    else if (k < 75) e = i_pad(pc);
    else e = mk(($urandom_range(0, 1) != 0) ? ADD : SUB, ALU, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), pc, 1'($urandom_range(0, 1)), 64'($urandom));
    e.pc[63:32] = $urandom;   // upper bits must be ignored by a 32-bit monitor
    return e;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic post(input scoreboard_entry_t e0, input scoreboard_entry_t e1,
                      input logic [1:0] ack, input logic clr);
    commit_instr[0] = e0;
    commit_instr[1] = e1;
    commit_ack      = ack;
    clear           = clr;
    @(posedge clk);
    push_expect();
  endtask

  task automatic cycle(input scoreboard_entry_t e0, input scoreboard_entry_t e1,
                       input logic [1:0] ack, input logic clr);
    @(negedge clk);
    if (clr) model_clear();
    else begin
      if (ack[0]) model_commit(e0);
      if (ack[1]) model_commit(e1);
    end
    post(e0, e1, ack, clr);
  endtask

  task automatic c1(input scoreboard_entry_t e);
    cycle(e, i_alu(32'h0), 2'b01, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(i_alu(32'h0), i_alu(32'h0), 2'b00, 1'b0);
  endtask

  task automatic do_clear();
    cycle(i_alu(32'h0), i_alu(32'h0), 2'b00, 1'b1);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL txn=%0d %s actual=0x%0h required=0x%0h", txn, name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        txn++;
        chk("state",    64'(st),    64'(s.state));
        chk("violated", 64'(viol),  64'(s.viol));
        chk("cause",    64'(cause), 64'(s.cause));
        chk("viol_pc",  64'(vpc),   64'(s.vpc));
        chk("count",    64'(cnt),   64'(s.count));
        chk("overflow", 64'(ovf),   64'(s.ovf));
        $display("txn %0d: state=%0d count=%0d viol=%0b cause=%0d vpc=0x%0h ovf=%0b",
                 txn, st, cnt, viol, cause, vpc, ovf);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    scoreboard_entry_t e[2];
    logic [1:0] ack;
    logic clr;

    rst_ni = 1'b0;
    clear  = 1'b0;
    commit_ack = 2'b00;
    commit_instr[0] = i_alu(32'h0);
    commit_instr[1] = i_alu(32'h0);
    idle(2);                                  // reset values
    @(negedge clk);
    rst_ni = 1'b1;
    idle(1);

    // matched call/return
    c1(i_call(32'h1000, 1'b0));
    c1(i_ret(32'h2000));
    c1(i_alu(32'h1004));

    // compressed call: link is 0x1002, so 0x1004 mismatches; violation held
    do_clear();
    c1(i_call(32'h1000, 1'b1));
    c1(i_ret(32'h2000));
    c1(i_alu(32'h1004));
    idle(3);
    c1(i_call(32'h5000, 1'b0));               // ignored while violated

    // underflow, then clear
    do_clear();
    c1(i_ret(32'h2000));
    do_clear();
    idle(1);

    // nine nested calls overflow; eight returns pass, ninth underflows
    for (int k = 0; k < 9; k++) c1(i_call(32'h6000 + 32'(k) * 32'h100, 1'b0));
    for (int k = 0; k < 9; k++) c1(i_ret((m_state == ST_RET) ? m_exp : 32'h7000));
    do_clear();

    // dual-port return + target check in one cycle
    c1(i_call(32'h3000, 1'b0));
    cycle(i_ret(32'h4000), i_alu(32'h3004), 2'b11, 1'b0);
    c1(i_call(32'h3000, 1'b0));
    cycle(i_ret(32'h4000), i_alu(32'h3008), 2'b11, 1'b0);
    do_clear();

    // both ports underflow: lowest port reported
    cycle(i_ret(32'hA000), i_ret(32'hA004), 2'b11, 1'b0);
    do_clear();

    // landing pads (violation only when the feature is built in)
    c1(i_ijmp(32'hB000));
    c1(i_pad(32'hC000));
    c1(i_ijmp(32'hB010));
    c1(i_alu(32'hC010));
    do_clear();

    // link address wraps modulo 2^PC_W
    c1(i_call(32'hFFFF_FFFE, 1'b1));
    c1(i_ret(32'h0100));
    c1(i_alu(32'h0000_0000));
    c1(i_call(32'hFFFF_FFFC, 1'b0));
    do_clear();

    // clear overrides commits in the same cycle
    c1(i_call(32'h8000, 1'b0));
    cycle(i_call(32'h8100, 1'b0), i_call(32'h8200, 1'b0), 2'b11, 1'b1);
    idle(1);

    // non-contiguous ack: only port 1 processed
    cycle(i_ret(32'h9999), i_call(32'h9000, 1'b0), 2'b10, 1'b0);
    cycle(i_ret(32'h9100), i_alu(32'h9004), 2'b11, 1'b0);
    do_clear();

    // randomized phase
    for (int n = 0; n < 220; n++) begin
      @(negedge clk);
      clr = ($urandom_range(0, 29) == 0) || (m_state == ST_VIOL && $urandom_range(0, 3) == 0);
      ack = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        e[p] = gen_instr();
        if (!clr && ack[p]) model_commit(e[p]);
      end
      if (clr) model_clear();
      post(e[0], e[1], ack, clr);
    end

    // leave a non-zero state, drain, then check the asynchronous reset
    do_clear();
    c1(i_call(32'hD000, 1'b0));
    c1(i_ret(32'hE000));
    idle(1);
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_state", 64'(st), 64'(ST_CHK));
    chk("async_rst_count", 64'(cnt), 64'd0);
    chk("async_rst_viol",  64'(viol), 64'd0);
    rst_ni = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
